div_unit: RTL

- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage beside the ALU and takes the same operand buses `a` and `b`.
- The ALU's combinational divide/remainder path is replaced by this block's registered result.
- Drives `busy`, which the hazard unit uses to stall the front end, and pulses `done` when `r` is ready for the writeback mux.

---
 rtl/div_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, followed by one sign-fix cycle before the result is presented.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] r
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic            rem_sel_q, rem_sel_d;
  logic            a_neg_q, a_neg_d;
  logic            b_neg_q, b_neg_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] r_q, r_d;

  logic            sgn, a_neg_in, b_neg_in, ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   p_shift;
  logic [XLEN-1:0] p_sub, quo_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      rem_sel_q <= 1'b0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      r_q       <= '0;
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
    end
  end

  always_comb begin
    sgn      = ~op[0];
    a_neg_in = sgn & a[XLEN-1];
    b_neg_in = sgn & b[XLEN-1];
    a_mag    = a_neg_in ? -a : a;
    b_mag    = b_neg_in ? -b : b;
    ovf      = sgn && (a == MIN_NEG) && (b == '1);

    // The partial remainder never reaches 2*divisor, so the low XLEN bits of the difference are exact.
    p_shift  = {1'b0, rem_q, quo_q[XLEN-1]};
    p_sub    = p_shift[XLEN-1:0] - div_q;
    quo_fix  = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
    rem_fix  = a_neg_q ? -rem_q : rem_q;

    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    r_d       = r_q;

    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            rem_sel_d = op[1];
            a_neg_d   = a_neg_in;
            b_neg_d   = b_neg_in;
            quo_d     = a_mag;
            div_d     = b_mag;
            rem_d     = '0;
            cnt_d     = CW'(XLEN - 1);
            if (b == '0) begin
              state_d = DONE;
              r_d     = op[1] ? a : '1;
            end else if (ovf) begin
              state_d = DONE;
              r_d     = op[1] ? '0 : MIN_NEG;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          if (p_shift >= {1'b0, div_q}) begin
            rem_d = p_sub;
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = p_shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
        FIX: begin
          r_d     = rem_sel_q ? rem_fix : quo_fix;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == CALC) || (state_q == FIX);
    done = (state_q == DONE);
    r    = r_q;
  end

endmodule
